param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo_if.sv | 48 ++++
 rtl/param_sync_fifo.sv | 138 +++++++++++++
 tb/tb_param_sync_fifo.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle for param_sync_fifo.
// The error flags exist only when FIFO_ERR_FLAGS_EN is defined.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  flush_i;
  logic                  write_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  read_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_valid_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic [CNT_W-1:0]      count_o;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow_o;
  logic                  underflow_o;
`endif

`ifdef FIFO_ERR_FLAGS_EN
  modport master (
    output flush_i, write_i, wr_data_i, read_i,
    input  rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
           almost_empty_o, count_o, overflow_o, underflow_o
  );
  modport slave (
    input  flush_i, write_i, wr_data_i, read_i,
    output rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
           almost_empty_o, count_o, overflow_o, underflow_o
  );
`else
  modport master (
    output flush_i, write_i, wr_data_i, read_i,
    input  rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
           almost_empty_o, count_o
  );
  modport slave (
    input  flush_i, write_i, wr_data_i, read_i,
    output rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
           almost_empty_o, count_o
  );
`endif
endinterface

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO of any depth with FWFT or registered read and registered flags.
// Define FIFO_ERR_FLAGS_EN to add the sticky overflow/underflow flags.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int FWFT       = 1,
  parameter int AFULL_THR  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input logic             clk_i,
  input logic             rst_n_i,
  param_sync_fifo_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef logic [AW-1:0] ptr_t;

  // Pointers wrap explicitly so depths that are not a power of two work.
  function automatic ptr_t nextPtr(input ptr_t p);
    return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  ptr_t          wrPtr_q, wrPtr_d;
  ptr_t          rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          wrAccept, rdAccept;

  // Acceptance looks only at registered flags; flush overrides both requests.
  always_comb begin
    wrAccept = bus.write_i & ~full_q  & ~bus.flush_i;
    rdAccept = bus.read_i  & ~empty_q & ~bus.flush_i;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    if (bus.flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (wrAccept) wrPtr_d = nextPtr(wrPtr_q);
      if (rdAccept) rdPtr_d = nextPtr(rdPtr_q);
      count_d = count_q + CW'(wrAccept) - CW'(rdAccept);
    end
    full_d   = (count_d == CW'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AFULL_THR));
    aempty_d = (count_d <= CW'(AEMPTY_THR));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage is never reset; stale words are hidden behind empty/rd_valid.
  always_ff @(posedge clk_i) begin
    if (wrAccept) mem[wrPtr_q] <= bus.wr_data_i;
  end

  assign bus.full_o         = full_q;
  assign bus.empty_o        = empty_q;
  assign bus.almost_full_o  = afull_q;
  assign bus.almost_empty_o = aempty_q;
  assign bus.count_o        = count_q;

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_data_o  = mem[rdPtr_q];
      assign bus.rd_valid_o = ~empty_q;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdData_q;
      logic                  rdValid_q;

      // Popped word is held until the next accepted read; valid pulses one cycle.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          rdData_q  <= '0;
          rdValid_q <= 1'b0;
        end else begin
          rdValid_q <= rdAccept;
          if (rdAccept) rdData_q <= mem[rdPtr_q];
        end
      end

      assign bus.rd_data_o  = rdData_q;
      assign bus.rd_valid_o = rdValid_q;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (bus.write_i & full_q);
    underflow_d = underflow_q | (bus.read_i  & empty_q);
    if (bus.flush_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;
`endif
endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: an FWFT and a registered-read FIFO (depth 5) share one stimulus
// stream and are compared against a queue-based reference model.
module tb_param_sync_fifo;
  localparam int DEPTH = 5;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       wr;
  logic [7:0] wdata;
  logic       rd;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         mOvf, mUnf, mStdValid;
  logic [7:0] mStdData;

  param_sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) busF ();
  param_sync_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) busS ();

  assign busF.flush_i   = flush;
  assign busF.write_i   = wr;
  assign busF.wr_data_i = wdata;
  assign busF.read_i    = rd;
  assign busS.flush_i   = flush;
  assign busS.write_i   = wr;
  assign busS.wr_data_i = wdata;
  assign busS.read_i    = rd;

  param_sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(1), .AFULL_THR(4), .AEMPTY_THR(1))
    dutF (.clk_i(clk), .rst_n_i(rst_n), .bus(busF));
  param_sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(0), .AFULL_THR(4), .AEMPTY_THR(1))
    dutS (.clk_i(clk), .rst_n_i(rst_n), .bus(busS));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic f, input logic w, input logic [7:0] d, input logic r);
    flush = f; wr = w; wdata = d; rd = r;
  endtask

  task automatic modelReset();
    q.delete();
    mOvf = 0; mUnf = 0; mStdValid = 0; mStdData = 8'h00;
  endtask

  // One clock edge, then advance the model from the inputs that edge sampled.
  task automatic tick();
    bit wrOk, rdOk;
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
      mOvf = 0; mUnf = 0; mStdValid = 0;
    end else begin
      wrOk = wr && (q.size() < DEPTH);
      rdOk = rd && (q.size() > 0);
      mStdValid = rdOk;
      if (rdOk) mStdData = q.pop_front();
      if (wrOk) q.push_back(wdata);
      if (wr && !wrOk) mOvf = 1;
      if (rd && !rdOk) mUnf = 1;
    end
    cyc++;
  endtask

  task automatic test_reset();
    modelReset();
    drive(0, 0, 8'h00, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    nCompared++; if (busF.empty_o !== 1'b1) begin nMismatched++; $display("FAIL reset_empty got=%b exp=1", busF.empty_o); end
    nCompared++; if (busF.almost_empty_o !== 1'b1) begin nMismatched++; $display("FAIL reset_aempty got=%b exp=1", busF.almost_empty_o); end
    nCompared++; if (busF.full_o !== 1'b0) begin nMismatched++; $display("FAIL reset_full got=%b exp=0", busF.full_o); end
    nCompared++; if (busF.almost_full_o !== 1'b0) begin nMismatched++; $display("FAIL reset_afull got=%b exp=0", busF.almost_full_o); end
    nCompared++; if (busF.count_o !== 3'd0) begin nMismatched++; $display("FAIL reset_count got=%0d exp=0", busF.count_o); end
    nCompared++; if (busF.rd_valid_o !== 1'b0) begin nMismatched++; $display("FAIL reset_fwft_valid got=%b exp=0", busF.rd_valid_o); end
    nCompared++; if (busS.rd_valid_o !== 1'b0) begin nMismatched++; $display("FAIL reset_std_valid got=%b exp=0", busS.rd_valid_o); end
    nCompared++; if (busS.rd_data_o !== 8'h00) begin nMismatched++; $display("FAIL reset_std_data got=%h exp=00", busS.rd_data_o); end
`ifdef FIFO_ERR_FLAGS_EN
    nCompared++; if (busF.overflow_o !== 1'b0 || busF.underflow_o !== 1'b0) begin nMismatched++; $display("FAIL reset_errflags got=%b%b exp=00", busF.overflow_o, busF.underflow_o); end
`endif
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'h11 + 8'(i), 0);
      tick();
      nCompared++; if (busF.count_o !== 3'(i + 1)) begin nMismatched++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, busF.count_o, i + 1); end
      nCompared++; if (busF.almost_full_o !== (i >= 3)) begin nMismatched++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, busF.almost_full_o, (i >= 3)); end
      nCompared++; if (busF.full_o !== (i == 4)) begin nMismatched++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, busF.full_o, (i == 4)); end
    end
    drive(0, 1, 8'hAA, 0);
    tick();
    nCompared++; if (busF.count_o !== 3'd5 || busF.full_o !== 1'b1) begin nMismatched++; $display("FAIL overflow_count got=%0d full=%b exp=5 full=1", busF.count_o, busF.full_o); end
`ifdef FIFO_ERR_FLAGS_EN
    nCompared++; if (busF.overflow_o !== 1'b1) begin nMismatched++; $display("FAIL overflow_flag got=%b exp=1", busF.overflow_o); end
`endif
    for (int i = 0; i < 5; i++) begin
      nCompared++; if (busF.rd_data_o !== 8'h11 + 8'(i) || busF.rd_valid_o !== 1'b1) begin nMismatched++; $display("FAIL drain_fwft i=%0d got=%h/%b exp=%h/1", i, busF.rd_data_o, busF.rd_valid_o, 8'h11 + 8'(i)); end
      drive(0, 0, 8'h00, 1);
      tick();
      nCompared++; if (busS.rd_data_o !== 8'h11 + 8'(i) || busS.rd_valid_o !== 1'b1) begin nMismatched++; $display("FAIL drain_std i=%0d got=%h/%b exp=%h/1", i, busS.rd_data_o, busS.rd_valid_o, 8'h11 + 8'(i)); end
    end
    nCompared++; if (busF.empty_o !== 1'b1 || busF.rd_valid_o !== 1'b0) begin nMismatched++; $display("FAIL drain_empty got=%b valid=%b exp=1/0", busF.empty_o, busF.rd_valid_o); end
    drive(0, 0, 8'h00, 0);
    tick();
  endtask

  task automatic test_wrap();
    int v = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) begin
        drive(0, 1, 8'(v + i), 0);
        tick();
      end
      for (int i = 0; i < 3; i++) begin
        nCompared++; if (busF.rd_data_o !== 8'(v)) begin nMismatched++; $display("FAIL wrap_fwft v=%0d got=%h exp=%h", v, busF.rd_data_o, 8'(v)); end
        drive(0, 0, 8'h00, 1);
        tick();
        nCompared++; if (busS.rd_data_o !== 8'(v)) begin nMismatched++; $display("FAIL wrap_std v=%0d got=%h exp=%h", v, busS.rd_data_o, 8'(v)); end
        v++;
      end
    end
    nCompared++; if (busF.count_o !== 3'd0) begin nMismatched++; $display("FAIL wrap_count got=%0d exp=0", busF.count_o); end
    drive(0, 0, 8'h00, 0);
  endtask

  task automatic test_simultaneous();
    drive(1, 0, 8'h00, 0); tick();
`ifdef FIFO_ERR_FLAGS_EN
    nCompared++; if (busF.overflow_o !== 1'b0) begin nMismatched++; $display("FAIL simul_preflush_ovf got=%b exp=0", busF.overflow_o); end
`endif
    drive(0, 1, 8'h21, 0); tick();
    drive(0, 1, 8'h22, 0); tick();
    drive(0, 1, 8'h23, 1); tick();
    nCompared++; if (busF.count_o !== 3'd2) begin nMismatched++; $display("FAIL simul_count2 got=%0d exp=2", busF.count_o); end
    nCompared++; if (busF.rd_data_o !== 8'h22 || busS.rd_data_o !== 8'h21) begin nMismatched++; $display("FAIL simul_data got=%h/%h exp=22/21", busF.rd_data_o, busS.rd_data_o); end
    for (int i = 0; i < 3; i++) begin drive(0, 1, 8'h24 + 8'(i), 0); tick(); end
    drive(0, 1, 8'h27, 1); tick();
    nCompared++; if (busF.count_o !== 3'd4 || busF.full_o !== 1'b0) begin nMismatched++; $display("FAIL simul_full_count got=%0d full=%b exp=4/0", busF.count_o, busF.full_o); end
    nCompared++; if (busF.rd_data_o !== 8'h23) begin nMismatched++; $display("FAIL simul_full_head got=%h exp=23", busF.rd_data_o); end
`ifdef FIFO_ERR_FLAGS_EN
    nCompared++; if (busF.overflow_o !== 1'b1) begin nMismatched++; $display("FAIL simul_full_ovf got=%b exp=1", busF.overflow_o); end
`endif
    for (int i = 0; i < 4; i++) begin drive(0, 0, 8'h00, 1); tick(); end
    drive(0, 1, 8'h28, 1); tick();
    nCompared++; if (busF.count_o !== 3'd1 || busF.rd_data_o !== 8'h28) begin nMismatched++; $display("FAIL simul_empty got=%0d/%h exp=1/28", busF.count_o, busF.rd_data_o); end
`ifdef FIFO_ERR_FLAGS_EN
    nCompared++; if (busF.underflow_o !== 1'b1) begin nMismatched++; $display("FAIL simul_empty_unf got=%b exp=1", busF.underflow_o); end
`endif
    drive(0, 0, 8'h00, 1); tick();
    drive(0, 0, 8'h00, 0);
  endtask

  task automatic test_std_read();
    drive(1, 0, 8'h00, 0); tick();
    drive(0, 1, 8'h5A, 0); tick();
    drive(0, 0, 8'h00, 1); tick();
    nCompared++; if (busS.rd_data_o !== 8'h5A || busS.rd_valid_o !== 1'b1) begin nMismatched++; $display("FAIL std_pop got=%h/%b exp=5a/1", busS.rd_data_o, busS.rd_valid_o); end
    drive(0, 0, 8'h00, 0); tick();
    nCompared++; if (busS.rd_valid_o !== 1'b0 || busS.rd_data_o !== 8'h5A) begin nMismatched++; $display("FAIL std_hold got=%h/%b exp=5a/0", busS.rd_data_o, busS.rd_valid_o); end
    drive(0, 0, 8'h00, 1); tick();
    nCompared++; if (busS.rd_valid_o !== 1'b0 || busF.count_o !== 3'd0) begin nMismatched++; $display("FAIL std_empty_read valid=%b count=%0d exp=0/0", busS.rd_valid_o, busF.count_o); end
`ifdef FIFO_ERR_FLAGS_EN
    nCompared++; if (busS.underflow_o !== 1'b1) begin nMismatched++; $display("FAIL std_underflow got=%b exp=1", busS.underflow_o); end
`endif
    drive(0, 0, 8'h00, 0);
  endtask

  task automatic test_flush();
    drive(1, 0, 8'h00, 0); tick();
    for (int i = 0; i < 6; i++) begin drive(0, 1, 8'h31 + 8'(i), 0); tick(); end
    for (int i = 0; i < 2; i++) begin drive(0, 0, 8'h00, 1); tick(); end
    nCompared++; if (busF.count_o !== 3'd3) begin nMismatched++; $display("FAIL flush_pre_count got=%0d exp=3", busF.count_o); end
`ifdef FIFO_ERR_FLAGS_EN
    nCompared++; if (busF.overflow_o !== 1'b1) begin nMismatched++; $display("FAIL flush_pre_ovf got=%b exp=1", busF.overflow_o); end
`endif
    drive(1, 1, 8'h99, 0); tick();
    nCompared++; if (busF.count_o !== 3'd0 || busF.empty_o !== 1'b1 || busF.almost_empty_o !== 1'b1) begin nMismatched++; $display("FAIL flush_state count=%0d empty=%b aempty=%b exp=0/1/1", busF.count_o, busF.empty_o, busF.almost_empty_o); end
    nCompared++; if (busF.full_o !== 1'b0 || busF.almost_full_o !== 1'b0 || busF.rd_valid_o !== 1'b0 || busS.rd_valid_o !== 1'b0) begin nMismatched++; $display("FAIL flush_flags full=%b afull=%b fv=%b sv=%b exp=0000", busF.full_o, busF.almost_full_o, busF.rd_valid_o, busS.rd_valid_o); end
`ifdef FIFO_ERR_FLAGS_EN
    nCompared++; if (busF.overflow_o !== 1'b0 || busF.underflow_o !== 1'b0) begin nMismatched++; $display("FAIL flush_errflags got=%b%b exp=00", busF.overflow_o, busF.underflow_o); end
`endif
    drive(0, 0, 8'h00, 0); tick();
    nCompared++; if (busF.count_o !== 3'd0) begin nMismatched++; $display("FAIL flush_write_dropped count=%0d exp=0", busF.count_o); end
    drive(0, 1, 8'h3C, 0); tick();
    nCompared++; if (busF.rd_data_o !== 8'h3C || busF.count_o !== 3'd1) begin nMismatched++; $display("FAIL flush_next_write got=%h/%0d exp=3c/1", busF.rd_data_o, busF.count_o); end
    drive(0, 0, 8'h00, 1); tick();
    nCompared++; if (busS.rd_data_o !== 8'h3C) begin nMismatched++; $display("FAIL flush_next_std got=%h exp=3c", busS.rd_data_o); end
    drive(0, 0, 8'h00, 0);
  endtask

  task automatic test_async_reset();
    drive(0, 1, 8'h61, 0); tick();
    drive(0, 1, 8'h62, 0); tick();
    drive(0, 0, 8'h00, 0);
    rst_n = 1'b0;
    #2;
    nCompared++; if (busF.count_o !== 3'd0 || busF.empty_o !== 1'b1 || busS.rd_data_o !== 8'h00) begin nMismatched++; $display("FAIL async_reset count=%0d empty=%b sdata=%h exp=0/1/00", busF.count_o, busF.empty_o, busS.rd_data_o); end
    #1 rst_n = 1'b1;
    modelReset();
    drive(0, 1, 8'h77, 0); tick();
    nCompared++; if (busF.rd_data_o !== 8'h77 || busF.count_o !== 3'd1) begin nMismatched++; $display("FAIL post_reset_write got=%h/%0d exp=77/1", busF.rd_data_o, busF.count_o); end
    drive(0, 0, 8'h00, 1); tick();
    nCompared++; if (busS.rd_data_o !== 8'h77 || busS.rd_valid_o !== 1'b1) begin nMismatched++; $display("FAIL post_reset_std got=%h/%b exp=77/1", busS.rd_data_o, busS.rd_valid_o); end
    drive(0, 0, 8'h00, 0);
  endtask

  task automatic test_random();
    int bias;
    int n;
    for (int i = 0; i < 400; i++) begin
      bias = (((i / 40) % 2) == 0) ? 75 : 25;
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < bias),
            8'($urandom), ($urandom_range(0, 99) < (100 - bias)));
      tick();
      n = q.size();
      nCompared++; if (busF.count_o !== 3'(n) || busS.count_o !== 3'(n)) begin nMismatched++; $display("FAIL rand_count cyc=%0d got=%0d/%0d exp=%0d", cyc, busF.count_o, busS.count_o, n); end
      nCompared++; if (busF.full_o !== (n == DEPTH) || busF.empty_o !== (n == 0)) begin nMismatched++; $display("FAIL rand_full_empty cyc=%0d got=%b%b exp=%b%b", cyc, busF.full_o, busF.empty_o, (n == DEPTH), (n == 0)); end
      nCompared++; if (busF.almost_full_o !== (n >= 4) || busF.almost_empty_o !== (n <= 1)) begin nMismatched++; $display("FAIL rand_almost cyc=%0d got=%b%b exp=%b%b", cyc, busF.almost_full_o, busF.almost_empty_o, (n >= 4), (n <= 1)); end
      nCompared++; if (busF.rd_valid_o !== (n > 0)) begin nMismatched++; $display("FAIL rand_fwft_valid cyc=%0d got=%b exp=%b", cyc, busF.rd_valid_o, (n > 0)); end
      if (n > 0) begin
        nCompared++; if (busF.rd_data_o !== q[0]) begin nMismatched++; $display("FAIL rand_fwft_data cyc=%0d got=%h exp=%h", cyc, busF.rd_data_o, q[0]); end
      end
      nCompared++; if (busS.rd_valid_o !== mStdValid || busS.rd_data_o !== mStdData) begin nMismatched++; $display("FAIL rand_std cyc=%0d got=%h/%b exp=%h/%b", cyc, busS.rd_data_o, busS.rd_valid_o, mStdData, mStdValid); end
`ifdef FIFO_ERR_FLAGS_EN
      nCompared++; if (busF.overflow_o !== mOvf || busF.underflow_o !== mUnf) begin nMismatched++; $display("FAIL rand_errflags cyc=%0d got=%b%b exp=%b%b", cyc, busF.overflow_o, busF.underflow_o, mOvf, mUnf); end
`endif
    end
    drive(0, 0, 8'h00, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0);
    test_reset();
    test_fill_overflow();
    test_wrap();
    test_simultaneous();
    test_std_read();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
